// File: rtl/ddr2_ring_reader_pkg.sv
// Shared definitions for the ddr2_ring_reader read-side consumer of the DDR2 capture ring.
// Optional feature macro: RB_READER_XCHECK_EN (see ddr2_ring_reader.sv).
package ddr2_ring_reader_pkg;

    localparam int DATA_W_DEF     = 16;
    localparam int PTR_W_DEF      = 3;
    localparam int BURST_LEN_DEF  = 8;
    localparam int CAS_LAT_DEF    = 4;
    localparam int SETTLE_CYC_DEF = 2;
    localparam int CNT_W          = 8;

    typedef logic [DATA_W_DEF-1:0] rb_word_t;
    typedef logic [PTR_W_DEF-1:0]  rb_ptr_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LATENCY = 3'd1,
        CAPTURE = 3'd2,
        SETTLE  = 3'd3,
        DRAIN   = 3'd4
    } rb_rd_state_t;

    // Down-counters terminate at zero, so a phase of N cycles loads N-1.
    function automatic logic [CNT_W-1:0] cntLoad(input int cycles);
        return CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/ddr2_ring_reader_rb_out_reg.sv
// One-entry valid/ready output register carrying a data word and its last flag.
module rb_out_reg #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              last_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic              last_o
);

    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic              last_q;

    // A load always wins over a pure drain, so a word accepted this cycle is replaced seamlessly.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
            last_q  <= last_i;
        end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign last_o  = last_q;

endmodule

// File: rtl/ddr2_ring_reader.sv
// Read-side consumer of the DDR2 capture ring: opens the listen window, then drains the burst.
// Optional macro RB_READER_XCHECK_EN enables the sticky X-detect flag xerr.
module ddr2_ring_reader
    import ddr2_ring_reader_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int PTR_W      = PTR_W_DEF,
    parameter int BURST_LEN  = BURST_LEN_DEF,
    parameter int CAS_LAT    = CAS_LAT_DEF,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_valid,
    output logic              rd_ready,
    output logic              listen,
    output logic [PTR_W-1:0]  readPtr,
    input  logic [DATA_W-1:0] dout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              xerr
);

    localparam int IDX_W = $clog2(BURST_LEN) + 1;

    rb_rd_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [PTR_W-1:0] base_q, base_d;
    logic             listen_q, listen_d;

    logic load;
    logic lastLoad;
    logic lastHs;

    // idx reaching BURST_LEN means every word has been loaded; only the final handshake remains.
    assign load     = (state_q == DRAIN) && (idx_q != IDX_W'(BURST_LEN)) && (!out_valid || out_ready);
    assign lastLoad = (idx_q == IDX_W'(BURST_LEN - 1));
    assign lastHs   = out_valid && out_ready && out_last;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        base_d   = base_q;
        listen_d = listen_q;
        unique case (state_q)
            IDLE: begin
                if (rd_valid) begin
                    state_d  = LATENCY;
                    cnt_d    = cntLoad(CAS_LAT);
                    idx_d    = '0;
                    listen_d = 1'b1;
                end
            end
            LATENCY: begin
                if (cnt_q == '0) begin
                    state_d = CAPTURE;
                    cnt_d   = cntLoad(BURST_LEN / 2);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            CAPTURE: begin
                if (cnt_q == '0) begin
                    state_d = SETTLE;
                    cnt_d   = cntLoad(SETTLE_CYC);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d  = DRAIN;
                    listen_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DRAIN: begin
                if (load) begin
                    idx_d = idx_q + IDX_W'(1);
                end
                if (lastHs) begin
                    state_d = IDLE;
                    base_d  = base_q + PTR_W'(BURST_LEN);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            base_q   <= '0;
            listen_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            base_q   <= base_d;
            listen_q <= listen_d;
        end
    end

    assign rd_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign listen   = listen_q;
    assign readPtr  = base_q + PTR_W'(idx_q);

    rb_out_reg #(
        .DATA_W (DATA_W)
    ) u_out_reg (
        .clk     (clk),
        .reset   (reset),
        .load_i  (load),
        .data_i  (dout),
        .last_i  (lastLoad),
        .ready_i (out_ready),
        .valid_o (out_valid),
        .data_o  (out_data),
        .last_o  (out_last)
    );

`ifdef RB_READER_XCHECK_EN
    logic xerr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            xerr_q <= 1'b0;
        end else if (load && $isunknown(dout)) begin
            xerr_q <= 1'b1;
        end
    end

    assign xerr = xerr_q;
`else
    assign xerr = 1'b0;
`endif

endmodule
